// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store.
// One transaction in flight; data wins ties unless fetch has waited STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  // state  | meaning
  // IDLE   | no transaction outstanding, request muxed to memory
  // BUSY_I | fetch granted, waiting for its m_rvalid
  // BUSY_D | load/store granted, waiting for its m_rvalid
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          flushed;
  logic          sel_i;
  logic          sel_d;
  logic          gnt_i;
  logic          gnt_d;
  logic          drop_i;

  always_comb begin
    sel_d  = (state == IDLE) & d_req & ~(if_req & (starve_cnt == STARVE_LIM));
    sel_i  = (state == IDLE) & if_req & ~sel_d;
    gnt_i  = m_gnt & sel_i;
    gnt_d  = m_gnt & sel_d;
    // a flush in the response cycle itself must already suppress it
    drop_i = if_flush | flushed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_d) begin
          state_nxt = BUSY_D;
        end else if (gnt_i) begin
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_be      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          m_req  = sel_i | sel_d;
          if_gnt = gnt_i;
          d_gnt  = gnt_d;
          if (sel_d) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
          end else if (sel_i) begin
            m_be   = '1;
            m_addr = if_addr;
          end
        end
        BUSY_I: begin
          if (m_rvalid && !drop_i) begin
            if_rvalid = 1'b1;
            if_rdata  = m_rdata;
          end
        end
        BUSY_D: begin
          if (m_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // counts data grants taken while fetch was waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (gnt_d) begin
      if (if_req) begin
        starve_cnt <= (starve_cnt == STARVE_LIM) ? STARVE_LIM : starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end else if (gnt_i) begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushed <= 1'b0;
    end else if (state_nxt == IDLE) begin
      flushed <= 1'b0;
    end else if (state == BUSY_I && if_flush) begin
      flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a memory/requester environment drives the DUT,
// a reference model predicts grants and routed responses through a scoreboard queue.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_gnt, m_rvalid;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit            is_d;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // environment state (stimulus process only)
  bit            if_pend, d_pend, mem_busy, mem_own_i;
  int            wait_cnt;
  logic [AW-1:0] rsp_addr;
  int            k_if, k_d, k_gnt, k_flush, k_lmin, k_lmax;

  task drive_cycle();
    @(posedge clk);
    #1;
    if (!if_pend && ($urandom % 100) < k_if) begin
      if_pend = 1'b1;
      if_addr = $urandom & ~32'h3;
    end
    if_req = if_pend;
    if (!d_pend && ($urandom % 100) < k_d) begin
      d_pend  = 1'b1;
      d_we    = $urandom_range(0, 1) == 1;
      d_be    = BW'($urandom);
      d_addr  = $urandom & ~32'h3;
      d_wdata = $urandom;
    end
    d_req = d_pend;
    m_gnt = !mem_busy && (($urandom % 100) < k_gnt);
    if (mem_busy && wait_cnt == 0) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_data(rsp_addr);
    end else begin
      m_rvalid = !mem_busy && (($urandom % 100) < 5);
      m_rdata  = $urandom;
      if (mem_busy) wait_cnt--;
    end
    if_flush = (mem_busy && mem_own_i) ? (($urandom % 100) < k_flush) : (($urandom % 100) < 5);
    @(negedge clk);
    if (if_gnt) if_pend = 1'b0;
    if (d_gnt) d_pend = 1'b0;
    if (mem_busy && m_rvalid) begin
      mem_busy = 1'b0;
    end else if (!mem_busy && m_req && m_gnt) begin
      mem_busy  = 1'b1;
      mem_own_i = if_gnt;
      rsp_addr  = m_addr;
      wait_cnt  = $urandom_range(k_lmin, k_lmax);
    end
  endtask

  task run_phase(input int p_if, input int p_d, input int p_gnt, input int p_flush,
                 input int lmin, input int lmax, input int ncyc);
    k_if = p_if; k_d = p_d; k_gnt = p_gnt; k_flush = p_flush; k_lmin = lmin; k_lmax = lmax;
    for (int c = 0; c < ncyc; c++) drive_cycle();
  endtask

  task clear_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    if_pend = 0; d_pend = 0; mem_busy = 0; mem_own_i = 0; wait_cnt = 0;
  endtask

  // stimulus
  initial begin
    bit found;
    clear_inputs();
    rst = 1'b0;
    if_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;

    run_phase(100,   0, 100,  0, 1, 1,  30);  // fetch alone, response two cycles after grant
    run_phase(100, 100, 100,  0, 0, 0,  40);  // both always requesting: starvation guard
    run_phase( 50, 100,  30,  0, 0, 2,  60);  // memory stalls grants
    run_phase(100,  20,  80, 40, 0, 3, 100);  // frequent fetch flushes
    run_phase( 60,  60,  60, 15, 0, 3, 400);

    // reset asynchronously while a data transaction is outstanding
    found = 0;
    k_if = 50; k_d = 100; k_gnt = 100; k_flush = 0; k_lmin = 2; k_lmax = 3;
    for (int c = 0; c < 200 && !found; c++) begin
      drive_cycle();
      if (mem_busy && !mem_own_i) found = 1;
    end
    check("busy_d_reached", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    if_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
    #2;
    rst = 1'b0;
    #1;
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_if_gnt", 64'(if_gnt), 64'd0);
    check("rst_d_gnt", 64'(d_gnt), 64'd0);
    check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;

    run_phase(60, 60, 70, 15, 0, 3, 300);
    run_phase( 0,  0, 100, 0, 0, 3,  30);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // reference model and monitor
  initial begin
    bit            busy = 0;
    bit            own_d = 0;
    bit            fl = 0;
    bit            sel_d, sel_i;
    int            starve = 0;
    exp_t          e;
    logic [DW-1:0] exp_data;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_m_req", 64'(m_req), 64'd0);
        check("reset_gnts", 64'({if_gnt, d_gnt}), 64'd0);
        check("reset_rvalids", 64'({if_rvalid, d_rvalid}), 64'd0);
        check("reset_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("reset_m_fields", 64'({m_we, m_be, m_addr}), 64'd0);
        check("reset_m_wdata", 64'(m_wdata), 64'd0);
        busy = 0; starve = 0; fl = 0;
        sb.delete();
      end else if (!busy) begin
        sel_d = d_req && !(if_req && starve == SMAX);
        sel_i = if_req && !sel_d;
        check("idle_m_req", 64'(m_req), 64'(sel_i || sel_d));
        check("if_gnt", 64'(if_gnt), 64'(m_gnt && sel_i));
        check("d_gnt", 64'(d_gnt), 64'(m_gnt && sel_d));
        check("idle_rvalids", 64'({if_rvalid, d_rvalid}), 64'd0);
        check("idle_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        check("starve_cnt", 64'(dut.starve_cnt), 64'(starve));
        if (sel_d) begin
          check("m_addr_d", 64'(m_addr), 64'(d_addr));
          check("m_we_d", 64'(m_we), 64'(d_we));
          check("m_be_d", 64'(m_be), 64'(d_be));
          check("m_wdata_d", 64'(m_wdata), 64'(d_wdata));
        end else if (sel_i) begin
          check("m_addr_i", 64'(m_addr), 64'(if_addr));
          check("m_we_i", 64'(m_we), 64'd0);
          check("m_be_i", 64'(m_be), 64'hF);
          check("m_wdata_i", 64'(m_wdata), 64'd0);
        end
        if (m_gnt && (sel_i || sel_d)) begin
          e.is_d = sel_d;
          e.addr = sel_d ? d_addr : if_addr;
          sb.push_back(e);
          busy  = 1;
          own_d = sel_d;
          fl    = 0;
          if (sel_d) starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
          else       starve = 0;
        end
      end else begin
        check("busy_m_req", 64'(m_req), 64'd0);
        check("busy_gnts", 64'({if_gnt, d_gnt}), 64'd0);
        if (!own_d && if_flush) fl = 1;
        if (m_rvalid) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: response with no expected entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            exp_data = mem_data(e.addr);
            if (e.is_d) begin
              check("d_rvalid", 64'(d_rvalid), 64'd1);
              check("d_rdata", 64'(d_rdata), 64'(exp_data));
              check("if_rvalid_on_d", 64'(if_rvalid), 64'd0);
            end else begin
              check("if_rvalid", 64'(if_rvalid), 64'(!fl));
              check("if_rdata", 64'(if_rdata), fl ? 64'd0 : 64'(exp_data));
              check("d_rvalid_on_i", 64'(d_rvalid), 64'd0);
            end
          end
          busy = 0;
        end else begin
          check("wait_rvalids", 64'({if_rvalid, d_rvalid}), 64'd0);
          check("wait_rdata", 64'({if_rdata, d_rdata}), 64'd0);
        end
      end
    end
  end

endmodule
